// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART constants: data width and default TX FIFO depth,
// used by the TX FIFO, the transmitter and the MMIO status decode.
package uart_tx_fifo_pkg;

   localparam int UART_DATA_WIDTH    = 8;
   localparam int UART_TX_FIFO_DEPTH = 8;

   // Width of an occupancy counter that must hold 0..depth inclusive.
   function automatic int fifo_cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the UART transmitter, first-word-fall-through.
// Ports: clk, reset (async, high), flush, overflow_clr;
//   enq_data/enq_valid/enq_ready (producer);
//   deq_data/deq_valid/deq_ready (transmitter);
//   count/full/empty/overflow (MMIO status).
module uart_tx_fifo
   import uart_tx_fifo_pkg::*;
#(
   parameter int DEPTH = UART_TX_FIFO_DEPTH,
   parameter int WIDTH = UART_DATA_WIDTH,
   localparam int CNT_W = fifo_cnt_w(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic [WIDTH-1:0] enq_data,
   input  logic             enq_valid,
   output logic             enq_ready,
   output logic [WIDTH-1:0] deq_data,
   output logic             deq_valid,
   input  logic             deq_ready,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty,
   output logic             overflow,
   input  logic             overflow_clr
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] cnt;
   logic             enq_fire;
   logic             deq_fire;

   // Status comes only from the registered count, so full/empty
   // never depend on the handshake inputs of the same cycle.
   assign full      = (cnt == CNT_W'(DEPTH));
   assign empty     = (cnt == '0);
   assign count     = cnt;
   assign enq_ready = ~full;
   assign deq_valid = ~empty;
   assign deq_data  = mem[rd_ptr];

   assign enq_fire = enq_valid & ~full & ~flush;
   assign deq_fire = deq_ready & ~empty & ~flush;

   always_ff @(posedge clk) begin
      if (enq_fire)
         mem[wr_ptr] <= enq_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (enq_fire)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (deq_fire)
            rd_ptr <= rd_ptr + PTR_W'(1);
         if (enq_fire && !deq_fire)
            cnt <= cnt + CNT_W'(1);
         else if (deq_fire && !enq_fire)
            cnt <= cnt - CNT_W'(1);
      end
   end

   // A dropped byte outranks a same-cycle clear so it is never missed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         overflow <= 1'b0;
      else if (enq_valid && full)
         overflow <= 1'b1;
      else if (overflow_clr)
         overflow <= 1'b0;
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: queue-based reference model,
// directed corner cases followed by randomized traffic.
module tb_uart_tx_fifo;

   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       flush = 1'b0;
   logic [7:0] enq_data = '0;
   logic       enq_valid = 1'b0;
   logic       enq_ready;
   logic [7:0] deq_data;
   logic       deq_valid;
   logic       deq_ready = 1'b0;
   logic [3:0] count;
   logic       full;
   logic       empty;
   logic       overflow;
   logic       overflow_clr = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [7:0] mq[$];
   logic [7:0] exp_q[$];
   logic       ovf = 1'b0;

   uart_tx_fifo dut (
      .clk(clk),
      .reset(reset),
      .flush(flush),
      .enq_data(enq_data),
      .enq_valid(enq_valid),
      .enq_ready(enq_ready),
      .deq_data(deq_data),
      .deq_valid(deq_valid),
      .deq_ready(deq_ready),
      .count(count),
      .full(full),
      .empty(empty),
      .overflow(overflow),
      .overflow_clr(overflow_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_status();
      int n;
      n = mq.size();
      chk("count", 32'(count), 32'(n));
      chk("full", 32'(full), 32'(n == DEPTH));
      chk("empty", 32'(empty), 32'(n == 0));
      chk("enq_ready", 32'(enq_ready), 32'(n != DEPTH));
      chk("deq_valid", 32'(deq_valid), 32'(n != 0));
      chk("overflow", 32'(overflow), 32'(ovf));
   endtask

   // Scoreboard monitor: every accepted head byte must be the oldest
   // byte the model says was enqueued.
   always @(negedge clk) begin
      if (!reset && !flush && deq_valid && deq_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL deq_data: got %0h expected no byte", deq_data);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (deq_data !== e) begin
               errors++;
               $display("FAIL deq_data: got %0h expected %0h at %0t",
                        deq_data, e, $time);
            end
         end
      end
   end

   // One clock: drive inputs, check status mid-cycle, then advance
   // the model on the rising edge.
   task automatic cyc(input logic ev, input logic [7:0] d,
                      input logic dr, input logic fl, input logic oc);
      bit enq_ok;
      bit deq_ok;
      enq_valid    = ev;
      enq_data     = d;
      deq_ready    = dr;
      flush        = fl;
      overflow_clr = oc;
      @(negedge clk);
      chk_status();
      @(posedge clk);
      if (ev && mq.size() == DEPTH)
         ovf = 1'b1;
      else if (oc)
         ovf = 1'b0;
      if (fl) begin
         mq.delete();
         exp_q.delete();
      end else begin
         enq_ok = ev && (mq.size() < DEPTH);
         deq_ok = dr && (mq.size() > 0);
         if (deq_ok)
            void'(mq.pop_front());
         if (enq_ok) begin
            mq.push_back(d);
            exp_q.push_back(d);
         end
      end
      #1;
   endtask

   task automatic idle();
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic push(input logic [7:0] d);
      cyc(1'b1, d, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic drain();
      for (int i = 0; i < DEPTH + 2; i++)
         cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic mid_reset();
      @(negedge clk);
      #2;
      reset = 1'b1;
      mq.delete();
      exp_q.delete();
      ovf = 1'b0;
      #1;
      chk_status();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      #2;
      reset = 1'b1;
      #1;
      chk_status();
      @(posedge clk);
      #1;
      reset = 1'b0;
      idle();

      push(8'hA5);
      idle();
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      idle();

      for (int i = 0; i < DEPTH; i++)
         push(8'(i));
      push(8'hFF);
      cyc(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
      idle();
      drain();
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      idle();

      for (int i = 0; i < 5; i++)
         push(8'($urandom));
      drain();
      for (int i = 0; i < 7; i++)
         push(8'(8'h10 + i));
      idle();
      drain();

      for (int i = 0; i < 3; i++)
         push(8'(8'h30 + i));
      cyc(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
      idle();
      drain();

      for (int i = 0; i < DEPTH; i++)
         push(8'(8'h40 + i));
      cyc(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
      idle();
      drain();
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

      cyc(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
      idle();
      drain();

      for (int i = 0; i < 4; i++)
         push(8'(8'h50 + i));
      cyc(1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
      idle();
      push(8'h5A);
      idle();
      drain();

      for (int i = 0; i < 400; i++)
         cyc(1'($urandom_range(0, 2) != 0), 8'($urandom),
             1'($urandom_range(0, 2) == 0),
             1'($urandom_range(0, 31) == 0),
             1'($urandom_range(0, 15) == 0));

      for (int i = 0; i < 6; i++)
         push(8'($urandom));
      mid_reset();
      idle();

      for (int i = 0; i < 200; i++)
         cyc(1'($urandom_range(0, 1)), 8'($urandom),
             1'($urandom_range(0, 1)), 1'b0, 1'b0);
      drain();
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte FIFO that sits directly upstream of the UART transmitter. It decouples the CPU/MMIO store path from the serial line rate: a producer pushes bytes at core speed, and the transmitter drains them one frame at a time over a ready/valid handshake. The read side is first-word-fall-through, so the head byte is always presented to the transmitter's data input. The block also provides occupancy, full/empty status and a sticky overflow flag for MMIO status reads.

Parameters:
DEPTH, 8, number of byte entries; power of two, minimum 2
WIDTH, 8, data width in bits; fixed at 8 for UART use
CNT_W, $clog2(DEPTH)+1, width of the occupancy count; derived, not overridden

Ports:
clk  in  1  system clock; all state updates on the rising edge
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous clear of all queued bytes
enq_data  in  WIDTH  byte to enqueue
enq_valid  in  1  producer has a byte
enq_ready  out  1  FIFO can accept; equals ~full
deq_data  out  WIDTH  head byte; drives the transmitter data input
deq_valid  out  1  head byte valid; equals ~empty; drives the transmitter valid input
deq_ready  in  1  consumer accepts the head byte; driven by the transmitter ready output
count  out  CNT_W  number of stored bytes, 0..DEPTH
full  out  1  count == DEPTH
empty  out  1  count == 0
overflow  out  1  sticky: an enqueue was attempted while full
overflow_clr  in  1  synchronous clear of overflow

Behaviour:
- Reset (asynchronous assert, effective immediately):
  - wr_ptr = rd_ptr = 0, count = 0, empty = 1, full = 0.
  - enq_ready = 1, deq_valid = 0, overflow = 0.
  - Storage array is not reset. deq_data is don't-care while deq_valid = 0.
- Enqueue: fires on a clk edge when enq_valid & enq_ready. The byte is written to mem[wr_ptr] and wr_ptr advances by 1 modulo DEPTH.
- Dequeue: fires on a clk edge when deq_valid & deq_ready. rd_ptr advances by 1 modulo DEPTH.
- deq_data = mem[rd_ptr], combinational (fall-through).
- Latency: a byte enqueued at edge N into an empty FIFO gives deq_valid = 1 with that byte on deq_data in the cycle after edge N. There is no same-cycle bypass.
- Count update per edge:
  - +1 on enqueue only.
  - −1 on dequeue only.
  - Unchanged when both fire or neither fires.
- full and empty are registered, or derived combinationally from the registered count. They must be glitch-free relative to clk.
- Full case: enq_ready = 0 even if deq_ready = 1 in the same cycle (no pass-through when full). An enqueue attempt while full (enq_valid = 1 & full = 1) sets overflow on that edge; the byte is dropped.
- Empty case: deq_valid = 0. enq_valid = 1 and deq_ready = 1 in the same cycle gives an enqueue only; count becomes 1.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. Full and empty are distinguished by count, not by pointer equality.
- flush: on the edge, wr_ptr = rd_ptr = 0 and count = 0. flush has priority over any enqueue or dequeue in the same cycle; neither takes effect. overflow is unaffected.
- overflow: set has priority over overflow_clr in the same cycle.
- Mid-frame flush or reset: the transmitter already holds its latched frame, so that frame completes independently. Only queued bytes are discarded.
- Consumer handshake: deq_ready from the transmitter is high only while idle. Each dequeue therefore corresponds to exactly one transmitted frame, and no byte is consumed twice.
- No combinational path from deq_ready to enq_ready, or from enq_valid to deq_valid.

Decomposition:
- Shared UART package: UART_DATA_WIDTH = 8 and the default TX FIFO depth constant. Both are shared with the transmitter and with the MMIO decode for count and overflow.
- No sub-module: pointer and count registers plus the storage array fit in one module.
- Storage is inferred as distributed RAM or registers, with a synchronous write and an asynchronous read.

Test Plan:
- Reset then idle: assert reset mid-cycle. Required: immediately empty = 1, full = 0, count = 0, enq_ready = 1, deq_valid = 0, overflow = 0.
- Single byte: enqueue 0xA5 with deq_ready = 0. Required: next cycle deq_valid = 1, deq_data = 0xA5, count = 1. Pulse deq_ready. Required: empty = 1, count = 0.
- Fill and overflow (DEPTH = 8): enqueue 0x00..0x07. Required: full = 1, enq_ready = 0, count = 8. Enqueue 0xFF. Required: overflow = 1, count = 8, and 0xFF never appears at deq_data. Drain with deq_ready = 1 held. Required: 0x00..0x07 in order; overflow stays 1 until overflow_clr.
- Wrap-around: enqueue 5, dequeue 5, enqueue 0x10..0x16 (7 bytes). Required: ordered output 0x10..0x16 across the pointer wrap; count peaks at 7.
- Simultaneous events:
  - count = 3, enqueue 0x33 and dequeue together. Required: count stays 3, the head advances, 0x33 appears last.
  - full plus enq_valid plus deq_ready. Required: count = 7, overflow = 1.
  - empty plus enq_valid plus deq_ready. Required: count = 1.
- Flush with traffic: count = 4; assert flush with enq_valid = 1 and deq_ready = 1. Required: next cycle count = 0, empty = 1, no byte written, overflow unchanged.
- Integration with the transmitter (125 MHz, 115200 baud): enqueue 0x55 then 0xC3 back-to-back. Required: serial_out carries two consecutive 10-bit frames, LSB first, 1085 clocks per bit; FIFO empty after the second dequeue.
